// File: rtl/rand_word_sched_if.sv
// Handshake bundle between rand_word_sched and its requesters.
//   req        : level request, one bit per requester (requester -> scheduler)
//   gnt        : one-hot grant, zero when idle           (scheduler -> requester)
//   rand_valid : rand_word is valid for the granted requester
//   rand_word  : assembled WORD_WIDTH-bit random word
//   rand_ack   : granted requester accepts rand_word
//   busy       : scheduler is in any state other than IDLE
// master modport is the scheduler side; slave modport is the requester side.
interface rand_word_sched_if #(
  parameter int WORD_WIDTH = 32,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    gnt;
  logic                  rand_valid;
  logic [WORD_WIDTH-1:0] rand_word;
  logic                  rand_ack;
  logic                  busy;

  modport master (
    input  req,
    input  rand_ack,
    output gnt,
    output rand_valid,
    output rand_word,
    output busy
  );

  modport slave (
    output req,
    output rand_ack,
    input  gnt,
    input  rand_valid,
    input  rand_word,
    input  busy
  );
endinterface

// File: rtl/rand_word_sched.sv
// Random-word scheduler: shares a free-running half-width LFSR between
// NUM_REQ requesters. Grants one requester at a time (round-robin), samples
// the LFSR twice SAMPLE_GAP edges apart, assembles {hi, lo}, optionally
// forces MSB and LSB to 1 (odd full-width prime candidate), and presents
// the word on a valid/ack handshake.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   lfsr_in : current LFSR state (WORD_WIDTH/2 bits)
//   bus     : master side of rand_word_sched_if (req/gnt/valid/word/ack/busy)
module rand_word_sched #(
  parameter int WORD_WIDTH    = 32,
  parameter int NUM_REQ       = 2,
  parameter int SAMPLE_GAP    = 16,
  parameter int FORCE_ODD_MSB = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WORD_WIDTH/2-1:0] lfsr_in,
  rand_word_sched_if.master       bus
);

  localparam int HALF  = WORD_WIDTH / 2;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_GAP - 1);

  typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI, VALID} state_t;

  state_t                state_reg, state_next;
  logic [PTR_W-1:0]      ptr_reg, ptr_next;
  logic [PTR_W-1:0]      win_reg, win_next;
  logic [NUM_REQ-1:0]    gnt_reg, gnt_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [HALF-1:0]       lo_reg, lo_next;
  logic [HALF-1:0]       hi_reg, hi_next;
  logic [WORD_WIDTH-1:0] word_reg, word_next;
  logic                  valid_reg, valid_next;

  // Round-robin candidates: slot gi looks at requester (ptr + gi) mod NUM_REQ,
  // so the lowest hitting slot is the first requester at or after ptr.
  logic [PTR_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;
  logic [PTR_W-1:0]   pick_idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand_idx[gi] = (int'(ptr_reg) + gi >= NUM_REQ)
                          ? PTR_W'(int'(ptr_reg) + gi - NUM_REQ)
                          : PTR_W'(int'(ptr_reg) + gi);
    assign cand_hit[gi] = bus.req[cand_idx[gi]];
  end

  // Descending scan so the lowest-numbered hitting slot wins.
  always_comb begin
    pick_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) pick_idx = cand_idx[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      win_reg   <= '0;
      gnt_reg   <= '0;
      cnt_reg   <= '0;
      lo_reg    <= '0;
      hi_reg    <= '0;
      word_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      win_reg   <= win_next;
      gnt_reg   <= gnt_next;
      cnt_reg   <= cnt_next;
      lo_reg    <= lo_next;
      hi_reg    <= hi_next;
      word_reg  <= word_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    win_next   = win_reg;
    gnt_next   = gnt_reg;
    cnt_next   = cnt_reg;
    lo_next    = lo_reg;
    hi_next    = hi_reg;
    word_next  = word_reg;
    valid_next = valid_reg;

    unique case (state_reg)
      IDLE: begin
        if (|bus.req) begin
          win_next   = pick_idx;
          gnt_next   = NUM_REQ'(1) << pick_idx;
          cnt_next   = '0;
          state_next = WAIT_LO;
        end
      end

      WAIT_LO: begin
        if (!bus.req[win_reg]) begin
          // Abort: pointer is not advanced, so the same requester keeps
          // priority on its next request.
          gnt_next   = '0;
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          lo_next    = lfsr_in;
          cnt_next   = '0;
          state_next = WAIT_HI;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      WAIT_HI: begin
        if (!bus.req[win_reg]) begin
          gnt_next   = '0;
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          hi_next   = lfsr_in;
          cnt_next  = '0;
          word_next = {hi_next, lo_reg};
          if (FORCE_ODD_MSB != 0) begin
            word_next[WORD_WIDTH-1] = 1'b1;
            word_next[0]            = 1'b1;
          end
          valid_next = 1'b1;
          state_next = VALID;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      VALID: begin
        // Ack wins over a simultaneous request drop.
        if (bus.rand_ack) begin
          valid_next = 1'b0;
          gnt_next   = '0;
          ptr_next   = (int'(win_reg) == NUM_REQ - 1) ? '0 : win_reg + 1'b1;
          state_next = IDLE;
        end else if (!bus.req[win_reg]) begin
          valid_next = 1'b0;
          gnt_next   = '0;
          state_next = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign bus.gnt        = gnt_reg;
  assign bus.rand_valid = valid_reg;
  assign bus.rand_word  = word_reg;
  assign bus.busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_rand_word_sched.sv
// Directed self-checking bench for rand_word_sched (WORD_WIDTH=32, NUM_REQ=2,
// SAMPLE_GAP=4, FORCE_ODD_MSB=1). Inputs change 1 time unit after a rising
// edge; outputs are checked at that same point.
module tb_rand_word_sched;
  localparam int WW = 32;
  localparam int NR = 2;
  localparam int SG = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] lfsr = 16'h0;

  int checks = 0;
  int errors = 0;

  logic [15:0] rr_lo   [4] = '{16'h0001, 16'h5550, 16'hFFFF, 16'h0000};
  logic [15:0] rr_hi   [4] = '{16'h0002, 16'h7FFF, 16'hFFFF, 16'h0000};
  logic [31:0] rr_word [4] = '{32'h80020001, 32'hFFFF5551, 32'hFFFFFFFF, 32'h80000001};

  rand_word_sched_if #(.WORD_WIDTH(WW), .NUM_REQ(NR)) bus ();

  rand_word_sched #(
    .WORD_WIDTH(WW), .NUM_REQ(NR), .SAMPLE_GAP(SG), .FORCE_ODD_MSB(1)
  ) dut (
    .clk(clk), .rst(rst), .lfsr_in(lfsr), .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [31:0] exp_word);
    check({tag, ".gnt"},   32'(bus.gnt), 32'h0);
    check({tag, ".valid"}, 32'(bus.rand_valid), 32'h0);
    check({tag, ".busy"},  32'(bus.busy), 32'h0);
    check({tag, ".word"},  bus.rand_word, exp_word);
  endtask

  // Called right after the grant edge E0. Drives lo at E0+SG and hi at
  // E0+2*SG with random filler in between, then checks the presented word.
  task automatic fill(input string tag, input logic [15:0] lo, input logic [15:0] hi,
                      input logic [31:0] exp_word, input logic [1:0] exp_gnt);
    for (int i = 1; i < SG; i++) begin
      lfsr = 16'($urandom);
      tick();
    end
    lfsr = lo;
    tick();
    for (int i = 1; i < SG; i++) begin
      lfsr = 16'($urandom);
      tick();
    end
    check({tag, ".prevalid"}, 32'(bus.rand_valid), 32'h0);
    lfsr = hi;
    tick();
    lfsr = 16'($urandom);
    check({tag, ".valid"}, 32'(bus.rand_valid), 32'h1);
    check({tag, ".word"},  bus.rand_word, exp_word);
    check({tag, ".gnt"},   32'(bus.gnt), 32'(exp_gnt));
    $display("txn %s: gnt=%b word=%08h", tag, bus.gnt, bus.rand_word);
  endtask

  initial begin
    bus.req      = 2'b00;
    bus.rand_ack = 1'b0;

    // Reset held with requests pending, then idle with no requests.
    bus.req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle("rst_hold", 32'h0);
    end
    rst = 1'b0;
    bus.req = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_idle("idle", 32'h0);
    end

    // Word assembly: {2BCD,1234} with MSB/LSB forced.
    bus.req = 2'b01;
    tick();
    check("asm.gnt0", 32'(bus.gnt), 32'h1);
    check("asm.busy0", 32'(bus.busy), 32'h1);
    fill("asm", 16'h1234, 16'h2BCD, 32'hABCD1235, 2'b01);
    bus.rand_ack = 1'b1;
    bus.req = 2'b00;
    tick();
    bus.rand_ack = 1'b0;
    check_idle("asm_ack", 32'hABCD1235);

    // Abort from WAIT_LO by requester 1; pointer (now 1) must not advance.
    bus.req = 2'b10;
    tick();
    check("abort.gnt", 32'(bus.gnt), 32'h2);
    tick();
    bus.req = 2'b00;
    tick();
    check_idle("abort", 32'hABCD1235);
    bus.req = 2'b11;
    tick();
    check("abort.ptr", 32'(bus.gnt), 32'h2);
    bus.req = 2'b00;
    tick();
    check("abort2.gnt", 32'(bus.gnt), 32'h0);
    $display("txn abort: done");

    // Round-robin from ptr=0 with both requesting and immediate acks.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("rr_rst", 32'h0);
    bus.req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr.gnt", 32'(bus.gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
      fill("rr", rr_lo[k], rr_hi[k], rr_word[k], (k % 2 == 0) ? 2'b01 : 2'b10);
      bus.rand_ack = 1'b1;
      tick();
      bus.rand_ack = 1'b0;
      check("rr.idle_gnt", 32'(bus.gnt), 32'h0);
      check("rr.idle_busy", 32'(bus.busy), 32'h0);
    end
    bus.req = 2'b00;
    tick();

    // Backpressure: word and grant hold for 20 cycles while LFSR moves.
    bus.req = 2'b01;
    tick();
    fill("bp", 16'h0F0E, 16'h7001, 32'hF0010F0F, 2'b01);
    for (int i = 0; i < 20; i++) begin
      lfsr = 16'($urandom);
      tick();
      check("bp.word", bus.rand_word, 32'hF0010F0F);
      check("bp.gnt", 32'(bus.gnt), 32'h1);
      check("bp.valid", 32'(bus.rand_valid), 32'h1);
    end
    bus.rand_ack = 1'b1;
    bus.req = 2'b00;
    tick();
    bus.rand_ack = 1'b0;
    check_idle("bp_ack", 32'hF0010F0F);

    // Reset while in WAIT_HI, then a fresh request with full latency.
    bus.req = 2'b01;
    tick();
    check("mid.gnt", 32'(bus.gnt), 32'h1);
    for (int i = 0; i < SG + 1; i++) begin
      lfsr = 16'($urandom);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("mid_rst", 32'h0);
    tick();
    check("mid.regnt", 32'(bus.gnt), 32'h1);
    fill("mid", 16'h0002, 16'h4000, 32'hC0000003, 2'b01);
    bus.rand_ack = 1'b1;
    bus.req = 2'b00;
    tick();
    bus.rand_ack = 1'b0;
    check_idle("mid_ack", 32'hC0000003);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rand_word_sched.md
# rand_word_sched

Random-word scheduler that shares the free-running 16-bit (WORD_WIDTH/2) LFSR between several requesters in the RSA datapath (e.g. prime-candidate generator, blinding-value generator). It grants one requester at a time round-robin, samples the LFSR twice with a configurable decorrelation gap, and assembles a WORD_WIDTH-bit word. It optionally forces the MSB and LSB to 1 so the word is a full-width odd prime candidate. It then presents the word on a valid/ack handshake.

## Interface
- WORD_WIDTH, 32, width of the assembled word; even, ≥ 4.
- NUM_REQ, 2, number of requesters; ≥ 1.
- SAMPLE_GAP, 16, clock edges between LFSR samples; ≥ 1. Use ≥ WORD_WIDTH/2 for fully refreshed bits.
- FORCE_ODD_MSB, 1, when 1, rand_word[WORD_WIDTH-1] and rand_word[0] are forced to 1.
- clk  input  1  clock; all logic rising-edge.
- rst  input  1  reset, synchronous, active-high.
- lfsr_in  input  WORD_WIDTH/2  current LFSR state (rand_out of the free-running LFSR).
- req  input  NUM_REQ  level request per requester.
- gnt  output  NUM_REQ  one-hot grant; zero when idle.
- rand_valid  output  1  rand_word valid for the granted requester.
- rand_word  output  WORD_WIDTH  assembled random word.
- rand_ack  input  1  granted requester accepts rand_word; sampled only while rand_valid=1.
- busy  output  1  high in any state other than IDLE.

## Operation
- Reset: state IDLE, gnt=0, rand_valid=0, rand_word=0, busy=0, round-robin pointer ptr=0, gap counter cnt=0, lo/hi half registers=0.
- IDLE:
  - If req≠0, select the first set bit searching from ptr upward, wrapping at NUM_REQ.
  - Register gnt one-hot to the winner, set cnt=0, go to WAIT_LO.
- WAIT_LO, each edge:
  - If req[winner]=0, abort: go to IDLE, clear gnt, leave ptr unchanged.
  - Else if cnt==SAMPLE_GAP-1, set lo<=lfsr_in, cnt<=0, go to WAIT_HI.
  - Else cnt<=cnt+1.
- WAIT_HI: same as WAIT_LO, but captures hi<=lfsr_in and goes to VALID.
  - On that edge, rand_word<={hi,lo}. When FORCE_ODD_MSB=1, bit WORD_WIDTH-1 and bit 0 are set to 1.
- VALID:
  - rand_valid=1. rand_word and gnt are stable.
  - If rand_ack=1, go to IDLE, rand_valid<=0, gnt<=0, ptr<=(winner+1) mod NUM_REQ.
  - Else if req[winner]=0, abort to IDLE, clear gnt and rand_valid, leave ptr unchanged.
  - rand_ack takes priority over a simultaneous req drop.
- rand_word holds its last value after handshake or abort. It changes only on the WAIT_HI capture edge or on reset.
- rand_ack outside VALID is ignored. Requests from non-granted requesters are ignored until the next IDLE.
- Reset asserted in any state returns everything to reset values on that edge. No partial word survives.

## Timing
- E0 is the edge at which IDLE samples req≠0. gnt and busy are high after E0.
- lo captured at edge E0+SAMPLE_GAP. hi captured at E0+2·SAMPLE_GAP.
- rand_valid is high after E0+2·SAMPLE_GAP. Request-to-valid latency is 2·SAMPLE_GAP cycles (32 with defaults).
- An ack in the first valid cycle is legal. rand_valid, gnt and busy fall after that edge.
- There is a mandatory single IDLE cycle between consecutive grants. Back-to-back word period is 2·SAMPLE_GAP+2 cycles minimum.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset/idle:
  - Stimulus: hold rst 3 cycles with req=2'b11, then release with req=0 for 10 cycles.
  - Response: gnt=0, rand_valid=0, rand_word=0, busy=0 throughout.
- Word assembly (SAMPLE_GAP=4, FORCE_ODD_MSB=1):
  - Stimulus: req=2'b01; lfsr_in=16'h1234 at E0+4, 16'h2BCD at E0+8.
  - Response: gnt=2'b01; rand_valid rises after E0+8 with rand_word=32'hABCD1235; ack drops rand_valid next edge.
- Round-robin fairness:
  - Stimulus: req=2'b11 held, ack each word immediately.
  - Response: gnt sequence 01,10,01,10; an IDLE cycle between grants; ptr wraps 0→1→0.
- Abort:
  - Stimulus: req=2'b10 granted; drop req[1] at E0+2 (SAMPLE_GAP=4).
  - Response: IDLE after next edge, gnt=0, rand_valid never rises, ptr unchanged (next req=2'b11 grants 2'b10).
- Hold under backpressure:
  - Stimulus: reach VALID, keep rand_ack=0 for 20 cycles while lfsr_in changes.
  - Response: rand_word and gnt constant; ack on cycle 21 completes the handshake.
- Reset mid-operation:
  - Stimulus: assert rst for one cycle while in WAIT_HI, then release.
  - Response: all outputs at reset values after that edge; a new req restarts with full 2·SAMPLE_GAP latency.
